// File: rtl/latch_write_driver.sv
// Sequences a data word into a level-sensitive latch bank: setup, enable pulse, hold,
// plus a separate clear strobe. Timing of each phase is set by parameters.
module latch_write_driver #(
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = 2,
   parameter int PULSE_CYC = 3,
   parameter int HOLD_CYC  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_clr,
   output logic             in_ready,
   output logic [WIDTH-1:0] lat_d,
   output logic             lat_en,
   output logic             lat_clr,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_PULSE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_CLEAR = 3'd4;

   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   logic [2:0] state_r;
   logic [2:0] state_nx_s;
   logic [3:0] cnt_r;
   logic [3:0] cnt_nx_s;
   logic       accept_s;

   // Only combinational output: a clear request in IDLE blocks write acceptance.
   always_comb begin
      in_ready = (state_r == ST_IDLE) && !in_clr;
   end

   // Next-state and counter reload logic.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      accept_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_clr) begin
               state_nx_s = ST_CLEAR;
               cnt_nx_s   = PULSE_LD;
            end else if (in_valid) begin
               state_nx_s = ST_SETUP;
               cnt_nx_s   = SETUP_LD;
               accept_s   = 1'b1;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            if (cnt_r == 4'd0) begin
               state_nx_s = ST_PULSE;
               cnt_nx_s   = PULSE_LD;
            end else begin
               cnt_nx_s = cnt_r - 4'd1;
            end
         end
         ST_PULSE: begin
            if (cnt_r == 4'd0) begin
               state_nx_s = ST_HOLD;
               cnt_nx_s   = HOLD_LD;
            end else begin
               cnt_nx_s = cnt_r - 4'd1;
            end
         end
         ST_HOLD, ST_CLEAR: begin
            if (cnt_r == 4'd0) begin
               state_nx_s = ST_IDLE;
            end else begin
               cnt_nx_s = cnt_r - 4'd1;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = 4'd0;
         end
      endcase
   end

   // State, counter and registered outputs; strobes decode the next state so they align with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         lat_d   <= '0;
         lat_en  <= 1'b0;
         lat_clr <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         if (accept_s) begin
            lat_d <= in_data;
         end else begin
            lat_d <= lat_d;
         end
         lat_en  <= (state_nx_s == ST_PULSE);
         lat_clr <= (state_nx_s == ST_CLEAR);
         busy    <= (state_nx_s != ST_IDLE);
         done    <= ((state_r == ST_HOLD) || (state_r == ST_CLEAR)) && (state_nx_s == ST_IDLE);
      end
   end

endmodule

// File: tb/tb_latch_write_driver.sv
// Randomized bench for latch_write_driver: default-timing and minimum-timing instances
// share stimulus and are each compared against a time-offset reference model.
module tb_latch_write_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_clr;
   logic [7:0] in_data;

   logic       rdy_a, en_a, clr_a, busy_a, done_a;
   logic [7:0] d_a;
   logic       rdy_b, en_b, clr_b, busy_b, done_b;
   logic [7:0] d_b;

   int total = 0;
   int bad   = 0;

   // Reference model: operation kind (0 none, 1 write, 2 clear) and edges since its start.
   int         op [2];
   int         k  [2];
   logic [7:0] md [2];
   int         sc [2] = '{2, 1};
   int         pc [2] = '{3, 1};
   int         hc [2] = '{2, 1};

   always #5 clk = ~clk;

   latch_write_driver #(.WIDTH(8), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) u_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_clr(in_clr),
      .in_ready(rdy_a), .lat_d(d_a), .lat_en(en_a), .lat_clr(clr_a), .busy(busy_a), .done(done_a)
   );

   latch_write_driver #(.WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_clr(in_clr),
      .in_ready(rdy_b), .lat_d(d_b), .lat_en(en_b), .lat_clr(clr_b), .busy(busy_b), .done(done_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int op_len(input int i);
      if (op[i] == 1) return sc[i] + pc[i] + hc[i];
      else            return pc[i];
   endfunction

   function automatic bit model_idle(input int i);
      return (op[i] == 0) || (k[i] >= op_len(i));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         op[i] = 0;
         k[i]  = 0;
         md[i] = 8'h00;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (model_idle(i)) begin
            if (in_clr) begin
               op[i] = 2;
               k[i]  = 0;
            end else if (in_valid) begin
               op[i] = 1;
               k[i]  = 0;
               md[i] = in_data;
            end else begin
               op[i] = 0;
            end
         end else begin
            k[i]++;
         end
      end
   endtask

   task automatic check_outs(input int i, input logic [7:0] d, input logic en, input logic clr,
                             input logic bsy, input logic dn);
      logic e_en, e_clr, e_busy, e_done;
      e_en   = (op[i] == 1) && (k[i] >= sc[i]) && (k[i] < sc[i] + pc[i]);
      e_clr  = (op[i] == 2) && (k[i] < pc[i]);
      e_busy = (op[i] != 0) && (k[i] < op_len(i));
      e_done = (op[i] != 0) && (k[i] == op_len(i));
      chk($sformatf("u%0d_lat_d", i), 32'(d), 32'(md[i]));
      chk($sformatf("u%0d_lat_en", i), 32'(en), 32'(e_en));
      chk($sformatf("u%0d_lat_clr", i), 32'(clr), 32'(e_clr));
      chk($sformatf("u%0d_busy", i), 32'(bsy), 32'(e_busy));
      chk($sformatf("u%0d_done", i), 32'(dn), 32'(e_done));
   endtask

   task automatic check_all();
      check_outs(0, d_a, en_a, clr_a, busy_a, done_a);
      check_outs(1, d_b, en_b, clr_b, busy_b, done_b);
   endtask

   // One clock cycle: apply inputs after the falling edge, check ready, then outputs after the next edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic c);
      in_valid = v;
      in_data  = d;
      in_clr   = c;
      #1;
      chk("u0_in_ready", 32'(rdy_a), 32'(model_idle(0) && !c));
      chk("u1_in_ready", 32'(rdy_b), 32'(model_idle(1) && !c));
      @(posedge clk);
      if (rst) model_edge();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b0;
      in_clr   = 1'b0;
      in_data  = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b1;

      // Single write with ignored requests and data churn while busy.
      cycle(1'b1, 8'hA5, 1'b0);
      for (int j = 0; j < 6; j++) cycle(j[0], 8'(j * 37), 1'b0);
      for (int j = 0; j < 3; j++) cycle(1'b0, 8'h00, 1'b0);

      // Clear and write requested together: clear wins.
      cycle(1'b1, 8'h55, 1'b1);
      for (int j = 0; j < 5; j++) cycle(1'b0, 8'h00, 1'b0);

      // Back-to-back writes with in_valid held high.
      for (int j = 0; j < 8; j++) cycle(1'b1, 8'h3C, 1'b0);
      for (int j = 0; j < 10; j++) cycle(1'b1, 8'hC3, 1'b0);
      for (int j = 0; j < 10; j++) cycle(1'b0, 8'h00, 1'b0);

      // Reset asserted while the enable pulse is active.
      cycle(1'b1, 8'h96, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      chk("u0_en_before_rst", 32'(en_a), 32'd1);
      rst = 1'b0;
      #1;
      model_reset();
      check_all();
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'h11, 1'b0);
      rst = 1'b1;
      cycle(1'b0, 8'h00, 1'b0);

      // Randomized traffic.
      for (int j = 0; j < 400; j++) begin
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 6) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/latch_write_driver.md
LATCH_WRITE_DRIVER -- requirements
Module: latch_write_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of the driven latch bank.
REQ-002 SHALL have parameter SETUP_CYC, default 2: cycles lat_d is stable before lat_en rises; legal range 1..15.
REQ-003 SHALL have parameter PULSE_CYC, default 3: cycles lat_en or lat_clr is held high; legal range 1..15.
REQ-004 SHALL have parameter HOLD_CYC, default 2: cycles lat_d is held after lat_en falls; legal range 1..15.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  input  1  write request carrying in_data.
REQ-008 SHALL have port in_data  input  WIDTH  word to be written into the latch bank.
REQ-009 SHALL have port in_clr  input  1  clear request for the latch bank; sampled in IDLE only.
REQ-010 SHALL have port in_ready  output  1  write request accepted on this edge when in_valid is also high.
REQ-011 SHALL have port lat_d  output  WIDTH  data bus to the latch D inputs.
REQ-012 SHALL have port lat_en  output  1  latch enable (transparent while high).
REQ-013 SHALL have port lat_clr  output  1  clear strobe to the latch bank.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse on completion of a write or clear.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, PULSE, HOLD, CLEAR, with one down-counter of 4 bits.
REQ-017 SHALL drive in_ready = (state==IDLE) && !in_clr, combinationally; it is the only non-registered output.
REQ-018 SHALL, in IDLE with in_clr high, enter CLEAR, load the counter with PULSE_CYC-1, and ignore in_valid that cycle (clear has priority).
REQ-019 SHALL, in IDLE with in_valid && in_ready, register in_data into lat_d, enter SETUP, and load the counter with SETUP_CYC-1.
REQ-020 SHALL, in SETUP/PULSE/HOLD/CLEAR, decrement the counter each cycle and leave the state when the counter is 0.
REQ-021 SHALL transition SETUP->PULSE (counter := PULSE_CYC-1), PULSE->HOLD (counter := HOLD_CYC-1), and HOLD->IDLE and CLEAR->IDLE.
REQ-022 SHALL register lat_en high exactly while state==PULSE and lat_clr high exactly while state==CLEAR; the two SHALL never be high together.
REQ-023 SHALL keep lat_d constant from the accept edge until the next accept; lat_d SHALL not change in SETUP, PULSE, HOLD or CLEAR.
REQ-024 SHALL pulse done for exactly one cycle, in the first IDLE cycle after HOLD or CLEAR.
REQ-025 SHALL, for a write accepted at edge N, raise lat_en after edge N+SETUP_CYC, lower it after edge N+SETUP_CYC+PULSE_CYC, and assert done after edge N+SETUP_CYC+PULSE_CYC+HOLD_CYC.
REQ-026 SHALL accept a new write in the same cycle done is high (back-to-back writes every SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles).
REQ-027 SHALL ignore in_valid, in_data and in_clr in every state other than IDLE; no request is queued.

Reset
REQ-028 SHALL, on rst low, asynchronously force state=IDLE, counter=0, lat_d=0, lat_en=0, lat_clr=0, busy=0, done=0.
REQ-029 SHALL, on reset mid-operation, drop lat_en or lat_clr immediately without completing the operation and without a done pulse.
REQ-030 SHALL leave reset on the first rising clk edge with rst high, and be able to accept a request on that edge.

Verification
REQ-031 Default params, in_valid=1, in_data=8'hA5 for one cycle at edge 0 -> lat_d=A5 after edge 0, lat_en high after edges 2..4, done high after edge 7, busy 1 for 7 cycles.
REQ-032 in_clr=1 and in_valid=1 together in IDLE -> in_ready=0, lat_clr high 3 cycles, lat_en stays 0, lat_d unchanged, then done.
REQ-033 Writes of 8'h3C and 8'hC3 issued back-to-back, in_valid held high -> second accepted on the done cycle, and lat_en pulses 8 cycles apart.
REQ-034 rst driven low while lat_en=1 -> lat_en and lat_d go to 0 without a clock edge, no done, and in_ready=1 after release.
REQ-035 in_valid pulsed and in_data toggled during SETUP/PULSE/HOLD -> no effect; lat_d stays at the accepted value.
REQ-036 SETUP_CYC=PULSE_CYC=HOLD_CYC=1 -> lat_en high exactly 1 cycle, done 3 cycles after accept.
